// File: rtl/mac_array_sequencer.sv
// Initiator-side driver for the mac_array west/north edge: loads the kernel,
// streams activations with optional per-row skew and waits for the returned valid pulses.
module mac_array_sequencer #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 1,
  parameter int len_bw  = 8,
  parameter int skew    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [len_bw-1:0]      cfg_len,
  input  logic [psum_bw*col-1:0] cfg_bias,
  input  logic [row*bw-1:0]      w_data,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [row*bw-1:0]      x_data,
  input  logic                   x_valid,
  output logic                   x_ready,
  output logic [row*bw-1:0]      in_w,
  output logic [psum_bw*col-1:0] in_n,
  output logic [2:0]             inst_w,
  input  logic [col-1:0]         valid,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [len_bw:0] COL_C = (len_bw+1)'(col);
  localparam logic [len_bw:0] ONE_C = (len_bw+1)'(1);

  // Handshake rule: a word moves on a rising edge where valid and ready are both
  // high; ready is a decode of the state register, so it is stable all cycle.
  logic [2:0]             state, state_nxt;
  logic [len_bw-1:0]      len_r, load_cnt, exec_cnt, vld_cnt;
  logic [psum_bw*col-1:0] bias_r;
  logic                   w_fire, x_fire, vld_hit;
  logic [len_bw:0]        load_inc, exec_inc, vld_inc;
  logic [row*bw-1:0]      stage_d;

  assign w_ready   = (state == LOAD);
  assign x_ready   = (state == EXEC);
  assign busy      = (state == LOAD) || (state == EXEC) || (state == DRAIN);
  assign done      = (state == FIN);
  assign dbg_state = state;
  assign in_n      = bias_r;

  assign w_fire  = w_valid & w_ready;
  assign x_fire  = x_valid & x_ready;
  assign vld_hit = valid[col-1] & busy;

  // One extra bit so a full-scale cfg_len compares without wrapping.
  assign load_inc = {1'b0, load_cnt} + ONE_C;
  assign exec_inc = {1'b0, exec_cnt} + ONE_C;
  assign vld_inc  = {1'b0, vld_cnt} + {{len_bw{1'b0}}, vld_hit};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (w_fire && load_inc == COL_C) state_nxt = (len_r == '0) ? DRAIN : EXEC;
      EXEC:    if (x_fire && exec_inc == {1'b0, len_r}) state_nxt = DRAIN;
      DRAIN:   if (vld_inc >= {1'b0, len_r}) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stage_d = '0;
    if (w_fire)      stage_d = w_data;
    else if (x_fire) stage_d = x_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_r    <= '0;
      bias_r   <= '0;
      load_cnt <= '0;
      exec_cnt <= '0;
      vld_cnt  <= '0;
      inst_w   <= 3'b000;
    end else begin
      state  <= state_nxt;
      inst_w <= {1'b0, x_fire, w_fire};
      if (state == IDLE && start) begin
        len_r    <= cfg_len;
        bias_r   <= cfg_bias;
        load_cnt <= '0;
        exec_cnt <= '0;
        vld_cnt  <= '0;
      end else begin
        if (w_fire)  load_cnt <= load_inc[len_bw-1:0];
        if (x_fire)  exec_cnt <= exec_inc[len_bw-1:0];
        if (vld_hit) vld_cnt  <= vld_inc[len_bw-1:0];
        if (state == FIN) bias_r <= '0;
      end
    end
  end

  // Row r gets r extra stages when skewed; inst_w is never delayed.
  for (genvar r = 0; r < row; r++) begin : g_row
    localparam int depth = (skew != 0) ? r : 0;
    logic [bw-1:0] sr [0:depth];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= depth; k++) sr[k] <= '0;
      end else begin
        sr[0] <= stage_d[r*bw +: bw];
        for (int k = 1; k <= depth; k++) sr[k] <= sr[k-1];
      end
    end

    assign in_w[r*bw +: bw] = sr[depth];
  end

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Bench for mac_array_sequencer: table of jobs plus randomized jobs, each checked against
// the expected instruction/data stream, skew geometry, bias, busy and done timing.
module tb_mac_array_sequencer;

  localparam int BW = 4;
  localparam int PSUM_BW = 16;
  localparam int ROW = 8;
  localparam int COL = 1;
  localparam int LEN_BW = 8;
  localparam int SKEW = 1;
  localparam int W = ROW*BW;

  logic                   clk, reset, start;
  logic [LEN_BW-1:0]      cfg_len;
  logic [PSUM_BW*COL-1:0] cfg_bias;
  logic [W-1:0]           w_data, x_data, in_w;
  logic                   w_valid, w_ready, x_valid, x_ready;
  logic [PSUM_BW*COL-1:0] in_n;
  logic [2:0]             inst_w, dbg_state;
  logic [COL-1:0]         valid;
  logic                   busy, done;

  mac_array_sequencer #(
    .bw(BW), .psum_bw(PSUM_BW), .row(ROW), .col(COL), .len_bw(LEN_BW), .skew(SKEW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .in_w(in_w), .in_n(in_n), .inst_w(inst_w), .valid(valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         len;
    logic [15:0] bias;
    int         pct;       // random valid probability when pat_n == 0
    int         lat;       // array valid latency, 1..8
    logic [7:0] pat;       // x_valid pattern from first x_ready cycle, then held 1
    int         pat_n;
    bit         restart;   // extra start pulses in EXEC and FIN
    int         abort;     // reset after this many activations (0 = none)
    int         exp_bubbles;
    int         kind;      // 0 random data, 1 directed nibbles, 2 skew word
  } job_t;

  logic [W-1:0] kern;
  logic [W-1:0] act_q[$];
  logic [W-1:0] exp_q[$];
  logic [2:0]   log_inst[$];
  logic [W-1:0] log_w[$];
  logic [15:0]  log_n[$];
  logic         log_done[$], log_busy[$], log_vld[$];

  task automatic run_job(input job_t j);
    logic [7:0] vpipe;
    int  k_idx, x_idx, pidx, i, done_idx, both_rdy, errs, n, first_nz, last_nz, nz_cnt;
    int  c001, c010, done_cnt, lastv, idx001, exp_done;
    bit  x_seen, abort_pending;
    logic [W-1:0] e;

    vpipe = '0; k_idx = 0; x_idx = 0; pidx = 0; i = 0; done_idx = -1; both_rdy = 0;
    x_seen = 0; abort_pending = 0;
    log_inst = {}; log_w = {}; log_n = {}; log_done = {}; log_busy = {}; log_vld = {};
    exp_q = {};
    exp_q.push_back(kern);
    foreach (act_q[a]) exp_q.push_back(act_q[a]);

    @(negedge clk);
    start = 1'b1; cfg_len = LEN_BW'(j.len); cfg_bias = j.bias;
    while (i < 3000) begin
      @(negedge clk);
      if (abort_pending) begin
        reset = 1'b1; start = 1'b0; w_valid = 1'b0; x_valid = 1'b0; valid = '0;
        @(negedge clk);
        chk("abort in_w", in_w, 0);
        chk("abort inst_w", inst_w, 0);
        chk("abort in_n", in_n, 0);
        chk("abort ready", {w_ready, x_ready}, 0);
        chk("abort busy/done", {busy, done}, 0);
        reset = 1'b0;
        done_cnt = 0; errs = 0;
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          valid = COL'($urandom_range(0, 1));
          if (done) done_cnt++;
          if (busy || inst_w != 3'b000) errs++;
        end
        valid = '0;
        chk("abort no done", done_cnt, 0);
        chk("abort stays idle", errs, 0);
        return;
      end
      log_inst.push_back(inst_w); log_w.push_back(in_w); log_n.push_back(in_n);
      log_done.push_back(done); log_busy.push_back(busy);
      if (w_ready && x_ready) both_rdy++;
      start = 1'b0; cfg_len = LEN_BW'($urandom); cfg_bias = PSUM_BW'($urandom);
      if (x_ready && !x_seen) begin
        x_seen = 1;
        if (j.restart) start = 1'b1;
      end
      if (done && done_idx < 0) begin
        done_idx = i;
        if (j.restart) start = 1'b1;
      end
      // array model: one valid pulse per execute, lat cycles later
      vpipe = {vpipe[6:0], inst_w == 3'b010};
      valid = COL'(vpipe[j.lat-1]);
      log_vld.push_back(vpipe[j.lat-1]);
      // kernel driver
      w_valid = (j.pat_n > 0) ? 1'b1 : ($urandom_range(0, 99) < j.pct);
      w_data  = (k_idx < COL) ? kern : W'($urandom);
      if (w_valid && w_ready) k_idx++;
      // activation driver
      if (j.pat_n > 0) begin
        x_valid = (x_seen && pidx < j.pat_n) ? j.pat[pidx] : 1'b1;
        if (x_seen) pidx++;
      end else begin
        x_valid = ($urandom_range(0, 99) < j.pct);
      end
      x_data = (x_idx < act_q.size()) ? act_q[x_idx] : W'($urandom);
      if (x_valid && x_ready) begin
        x_idx++;
        if (j.abort > 0 && x_idx == j.abort) abort_pending = 1;
      end
      if (done_idx >= 0 && i >= done_idx + ROW + 2) break;
      i++;
    end
    w_valid = 1'b0; x_valid = 1'b0; valid = '0; start = 1'b0;

    if (done_idx < 0) begin
      chk("done timeout", 0, 1);
      return;
    end

    c001 = 0; c010 = 0; done_cnt = 0; idx001 = -1; lastv = -1;
    first_nz = -1; last_nz = -1; nz_cnt = 0;
    foreach (log_inst[t]) begin
      if (log_inst[t] == 3'b001) begin c001++; if (idx001 < 0) idx001 = t; end
      if (log_inst[t] == 3'b010) c010++;
      if (log_inst[t] != 3'b000) begin
        if (first_nz < 0) first_nz = t;
        last_nz = t; nz_cnt++;
      end
      if (log_done[t]) done_cnt++;
      if (log_vld[t] && t < done_idx) lastv = t;
    end
    chk("kernel loads", c001, COL);
    chk("executes", c010, j.len);
    chk("done count", done_cnt, 1);
    exp_done = (j.len == 0) ? idx001 + 1 : lastv + 1;
    chk("done position", done_idx, exp_done);
    if (j.exp_bubbles >= 0) chk("bubbles", (last_nz - first_nz + 1) - nz_cnt, j.exp_bubbles);
    chk("both ready", both_rdy, 0);

    // de-skewed stream: row r at cycle t+r must carry the word issued at cycle t
    errs = 0; n = 0;
    foreach (log_inst[t]) begin
      e = '0;
      if (log_inst[t] != 3'b000) begin
        if (n < exp_q.size()) e = exp_q[n];
        if (log_inst[t] != ((n < COL) ? 3'b001 : 3'b010)) errs++;
        n++;
      end
      for (int r = 0; r < ROW; r++) begin
        int tt;
        tt = t + ((SKEW != 0) ? r : 0);
        if (tt < log_w.size() && log_w[tt][r*BW +: BW] !== e[r*BW +: BW]) errs++;
      end
    end
    chk("stream data", errs, 0);

    errs = 0;
    foreach (log_busy[t]) begin
      if (log_busy[t] !== (t < done_idx)) errs++;
      if (log_n[t] !== ((t <= done_idx) ? j.bias : 16'd0)) errs++;
    end
    chk("busy and in_n", errs, 0);
  endtask

  logic [W-1:0] dir_acts [5];
  job_t tab [8];

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_bias = '0;
    w_data = '0; w_valid = 1'b0; x_data = '0; x_valid = 1'b0; valid = '0;
    repeat (3) @(negedge clk);
    chk("reset in_w", in_w, 0);
    chk("reset in_n", in_n, 0);
    chk("reset inst_w", inst_w, 0);
    chk("reset w_ready", w_ready, 0);
    chk("reset x_ready", x_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    dir_acts = '{32'h11111111, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'h99999999, 32'hFFFFFFFF};
    tab[0] = '{len:5,   bias:16'd2,      pct:100, lat:3, pat:8'b1,     pat_n:1, restart:0, abort:0, exp_bubbles:0,  kind:1};
    tab[1] = '{len:1,   bias:16'd0,      pct:100, lat:2, pat:8'b1,     pat_n:1, restart:0, abort:0, exp_bubbles:0,  kind:2};
    tab[2] = '{len:3,   bias:16'h0123,   pct:100, lat:4, pat:8'b11001, pat_n:5, restart:0, abort:0, exp_bubbles:2,  kind:0};
    tab[3] = '{len:0,   bias:16'hBEEF,   pct:100, lat:1, pat:8'b1,     pat_n:1, restart:0, abort:0, exp_bubbles:0,  kind:0};
    tab[4] = '{len:5,   bias:16'h00AA,   pct:100, lat:3, pat:8'b1,     pat_n:1, restart:0, abort:2, exp_bubbles:-1, kind:0};
    tab[5] = '{len:5,   bias:16'h5555,   pct:100, lat:3, pat:8'b1,     pat_n:1, restart:0, abort:0, exp_bubbles:0,  kind:0};
    tab[6] = '{len:4,   bias:16'hFFFF,   pct:70,  lat:5, pat:8'b0,     pat_n:0, restart:1, abort:0, exp_bubbles:-1, kind:0};
    tab[7] = '{len:255, bias:16'h8001,   pct:100, lat:2, pat:8'b1,     pat_n:1, restart:0, abort:0, exp_bubbles:0,  kind:0};

    for (int e = 0; e < 8; e++) begin
      act_q = {};
      kern = W'($urandom);
      if (tab[e].kind == 1) begin
        kern = 32'hFFFFFFFF;
        foreach (dir_acts[a]) act_q.push_back(dir_acts[a]);
      end else if (tab[e].kind == 2) begin
        act_q.push_back(32'h87654321);
      end else begin
        for (int a = 0; a < tab[e].len; a++) act_q.push_back(W'($urandom));
      end
      run_job(tab[e]);
      repeat (2) @(negedge clk);
    end

    for (int k = 0; k < 6; k++) begin
      job_t j;
      j = '{len:$urandom_range(0, 24), bias:16'($urandom), pct:$urandom_range(30, 100),
            lat:$urandom_range(1, 8), pat:8'b0, pat_n:0, restart:1'($urandom_range(0, 1)),
            abort:0, exp_bubbles:-1, kind:0};
      kern = W'($urandom);
      act_q = {};
      for (int a = 0; a < j.len; a++) act_q.push_back(W'($urandom));
      run_job(j);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_array_sequencer.md
Name: mac_array_sequencer

Overview:
- Initiator-side driver for the mac_array west/north edge.
- Accepts a kernel stream and an activation stream over valid/ready handshakes.
- Issues the kernel-load and execute instruction sequence on inst_w/in_w, with optional per-row skew.
- Counts valid pulses returned by the array and reports completion. Replaces the hand-written stimulus previously used to drive mac_array.

Parameters:
- bw, 4, activation/weight element width
- psum_bw, 16, partial-sum width
- row, 8, array rows (elements per in_w vector)
- col, 1, array columns (kernel words loaded per job)
- len_bw, 8, width of the activation-count field
- skew, 1, 1 = row r of in_w delayed r cycles; 0 = all rows aligned

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a job when IDLE, ignored otherwise
- cfg_len  in  len_bw  activation vectors per job, sampled on start; 0 = job of zero vectors
- cfg_bias  in  psum_bw*col  north psum seed, sampled on start
- w_data  in  row*bw  kernel vector (one per column)
- w_valid  in  1  kernel vector valid
- w_ready  out  1  kernel vector accepted when w_valid&w_ready
- x_data  in  row*bw  activation vector
- x_valid  in  1  activation valid
- x_ready  out  1  activation accepted when x_valid&x_ready
- in_w  out  row*bw  to mac_array in_w
- in_n  out  psum_bw*col  to mac_array in_n
- inst_w  out  3  to mac_array inst_w; [0] kernel load, [1] execute, [2] reserved, always 0
- valid  in  col  from mac_array valid
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset outputs: in_w=0, in_n=0, inst_w=000, w_ready=0, x_ready=0, busy=0, done=0. FSM goes to IDLE, all counters and skew registers are cleared.
- Reset mid-job aborts the job immediately. No done pulse is issued, and nothing accepted before reset is replayed.
- FSM states: IDLE, LOAD, EXEC, DRAIN, FIN.
- IDLE -> LOAD on start. Latch cfg_len into len_r and cfg_bias into bias_r. Clear load_cnt, exec_cnt and vld_cnt.
- LOAD:
  - w_ready=1.
  - Each handshake drives in_w=w_data and inst_w=001 in the next cycle, and increments load_cnt.
  - When load_cnt reaches col: go to EXEC, or to DRAIN if len_r==0.
- EXEC:
  - x_ready=1.
  - Each handshake drives in_w=x_data and inst_w=010 in the next cycle, and increments exec_cnt.
  - When exec_cnt reaches len_r: go to DRAIN.
- Bubbles: a cycle with no handshake in LOAD/EXEC drives inst_w=000 and in_w=0 in the next cycle. Stalls of any length are legal.
- All outputs are registered: one-cycle latency from handshake to in_w/inst_w (plus skew).
- Skew (skew=1):
  - in_w row r slice passes through r extra register stages, r=0..row-1.
  - inst_w is not skewed, because the array propagates it internally.
  - Row 0 therefore sees data in the same cycle as inst_w.
- in_n = bias_r for the whole job from the LOAD entry cycle onward; 0 in IDLE.
- vld_cnt increments on each cycle where valid[col-1]=1 during LOAD/EXEC/DRAIN. valid pulses in IDLE/FIN are ignored.
- DRAIN: w_ready=x_ready=0, inst_w=000. When vld_cnt==len_r, go to FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- start while busy is ignored. start in the FIN cycle is also ignored.
- w_ready and x_ready are never high simultaneously. Kernel loading always completes before any activation is accepted.
- Counters are len_bw wide. cfg_len = 2^len_bw-1 must work with no wrap before the compare.

Test Plan:
- Directed job, row=8, col=1, bias=2, len=5, in-order waveform check.
  - Stimulus: start; kernel 32'hFFFFFFFF; activations 1, C, D, 9, F with valid held high; array model returns 5 valid pulses.
  - Required: inst_w sequence 001, 010×5, 000; in_n=2 throughout the job; done exactly one cycle after the 5th valid.
- Skew check.
  - Stimulus: single activation 32'h87654321, skew=1.
  - Required: in_w row r nibble equals r+1 exactly r cycles after row 0's; all other cycles 0.
- Stall handling.
  - Stimulus: x_valid toggles 1,0,0,1,1 with len=3.
  - Required: two 000 bubbles inserted between the 1st and 2nd 010; exec_cnt stops at 3; extra x_valid is not accepted (x_ready=0).
- Zero-length job.
  - Stimulus: cfg_len=0.
  - Required: one 001 load, then DRAIN→FIN immediately; done pulse with no 010 ever issued.
- Reset mid-EXEC.
  - Stimulus: reset asserted after 2 of 5 activations.
  - Required: all outputs 0 the next cycle, busy=0, no done pulse; a new start runs a full job cleanly.
- Start while busy.
  - Stimulus: second start pulse during EXEC, and another during FIN.
  - Required: both ignored; exactly one done; cfg_len changes after start have no effect.
